sequential_shift_of_n_by_variable_s: RTL and testbench

Bit-serial shifter that accepts an N-bit operand, a runtime shift amount and an operation code over a valid/ready handshake. It performs one single-bit shift per clock cycle, then presents the result on a valid/ready output port. It is the sequential, variable-amount counterpart of the constant-amount combinational shifters in the arithmetic section. It sits between an upstream producer and a downstream consumer wherever area matters more than latency.

---
 rtl/sequential_shift_of_n_by_variable_s.sv | 160 ++++++++++++++++
 tb/tb_sequential_shift_of_n_by_variable_s.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_shift_of_n_by_variable_s.sv
// ---------------------------------------------------------------------------
// sequential_shift_of_n_by_variable_s
//
// Bit-serial variable-amount shifter. An operand, a shift amount and an
// operation code are accepted over a valid/ready handshake. One single-bit
// shift is applied per clock cycle until the requested amount is consumed.
// The result is then held on a valid/ready output port until the consumer
// takes it. Only one operation is in flight at a time.
//
// Parameters
//   N   operand/result width (N >= 2)
//   SW  shift-amount width, legal amounts 0..N-1
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   up_valid    upstream offers an operation
//   up_ready    block is idle and can accept an operation
//   up_data     operand (N bits)
//   up_amount   shift amount (SW bits)
//   up_op       00 logical left, 01 logical right,
//               10 arithmetic right, 11 rotate right
//   down_valid  result available
//   down_ready  downstream accepts the result
//   down_data   result (N bits)
// ---------------------------------------------------------------------------
module sequential_shift_of_n_by_variable_s #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amount,
  input  logic [1:0]    up_op,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]    OP_SLL = 2'b00;
  localparam logic [1:0]    OP_SRL = 2'b01;
  localparam logic [1:0]    OP_SRA = 2'b10;
  localparam logic [1:0]    OP_ROR = 2'b11;
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);
  localparam logic [SW-1:0] CNT_ZERO = '0;

  state_t        state_r, state_next;
  logic [N-1:0]  data_r, data_next;
  logic [SW-1:0] cnt_r, cnt_next;
  logic [1:0]    op_r, op_next;

  // Single-position shifted versions of data_r.
  logic [N-1:0]  left_one;
  logic [N-1:0]  right_one;
  logic [N-1:0]  shift_one;
  logic          right_fill;

  // Bit shifted into the MSB on a right shift: zero for logical, the
  // current MSB for arithmetic (so the sign persists across every step),
  // the outgoing LSB for rotate.
  always_comb begin
    right_fill = 1'b0;
    case (op_r)
      OP_SRL:  right_fill = 1'b0;
      OP_SRA:  right_fill = data_r[N-1];
      OP_ROR:  right_fill = data_r[0];
      default: right_fill = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign left_one[gi] = 1'b0;
      end else begin : g_lsb_n
        assign left_one[gi] = data_r[gi-1];
      end

      if (gi == N-1) begin : g_msb
        assign right_one[gi] = right_fill;
      end else begin : g_msb_n
        assign right_one[gi] = data_r[gi+1];
      end
    end
  endgenerate

  assign shift_one = (op_r == OP_SLL) ? left_one : right_one;

  // Handshake outputs are pure decodes of the state.
  assign up_ready   = (state_r == IDLE);
  assign down_valid = (state_r == DONE);
  assign down_data  = data_r;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      data_r  <= '0;
      cnt_r   <= '0;
      op_r    <= OP_SLL;
    end else begin
      state_r <= state_next;
      data_r  <= data_next;
      cnt_r   <= cnt_next;
      op_r    <= op_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state_r;
    data_next  = data_r;
    cnt_next   = cnt_r;
    op_next    = op_r;

    case (state_r)
      IDLE: begin
        if (up_valid) begin
          data_next = up_data;
          cnt_next  = up_amount;
          op_next   = up_op;
          // A zero amount skips SHIFT entirely: the operand is the result.
          state_next = (up_amount == CNT_ZERO) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        data_next = shift_one;
        cnt_next  = cnt_r - CNT_ONE;
        // cnt_r counts the shifts still to apply including this one, so
        // a value of one means this cycle's shift is the final one.
        if (cnt_r == CNT_ONE) begin
          state_next = DONE;
        end
      end

      DONE: begin
        // data_r is left untouched after the handoff; it is not observed
        // again until the next operation overwrites it.
        if (down_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sequential_shift_of_n_by_variable_s.sv
module tb_sequential_shift_of_n_by_variable_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       up_valid8, up_ready8, down_valid8, down_ready8;
  logic [7:0] up_data8, down_data8;
  logic [2:0] up_amount8;
  logic [1:0] up_op8;

  logic        up_valid16, up_ready16, down_valid16, down_ready16;
  logic [15:0] up_data16, down_data16;
  logic [3:0]  up_amount16;
  logic [1:0]  up_op16;

  sequential_shift_of_n_by_variable_s #(.N(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid8),
    .up_ready   (up_ready8),
    .up_data    (up_data8),
    .up_amount  (up_amount8),
    .up_op      (up_op8),
    .down_valid (down_valid8),
    .down_ready (down_ready8),
    .down_data  (down_data8)
  );

  sequential_shift_of_n_by_variable_s #(.N(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid16),
    .up_ready   (up_ready16),
    .up_data    (up_data16),
    .up_amount  (up_amount16),
    .up_op      (up_op16),
    .down_valid (down_valid16),
    .down_ready (down_ready16),
    .down_data  (down_data16)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic [7:0]  exp8_m;
  logic [15:0] exp16_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Combinational reference of an n-bit shift by s.
  function automatic logic [31:0] ref_shift(input logic [31:0] a_in, input int s,
                                            input logic [1:0] op, input int n);
    logic [31:0] mask, a, r;
    mask = (32'd1 << n) - 32'd1;
    a = a_in & mask;
    r = '0;
    case (op)
      2'b00: r = a << s;
      2'b01: r = a >> s;
      2'b10: begin
        r = a >> s;
        if (a[n-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = (a >> s) | (a << (n - s));
    endcase
    return r & mask;
  endfunction

  // Output monitors: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && down_valid8 === 1'b1 && down_ready8 === 1'b1) begin
      checks++;
      assert (q8.size() > 0) else begin
        errors++;
        $error("FAIL out8_unexpected: observed result %0h expected none", down_data8);
      end
      if (q8.size() > 0) begin
        exp8_m = q8.pop_front();
        chk("data8", {24'd0, down_data8}, {24'd0, exp8_m});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && down_valid16 === 1'b1 && down_ready16 === 1'b1) begin
      checks++;
      assert (q16.size() > 0) else begin
        errors++;
        $error("FAIL out16_unexpected: observed result %0h expected none", down_data16);
      end
      if (q16.size() > 0) begin
        exp16_m = q16.pop_front();
        chk("data16", {16'd0, down_data16}, {16'd0, exp16_m});
      end
    end
  end

  // One 8-bit operation with down_ready held high; checks handshake timing.
  // Starts and ends just after a rising edge with the DUT idle.
  task automatic run8(input logic [7:0] d, input int amt, input logic [1:0] op,
                      input logic [7:0] exp);
    up_valid8  = 1'b1;
    up_data8   = d;
    up_amount8 = 3'(amt);
    up_op8     = op;
    @(negedge clk);
    chk("up_ready_accept", {31'd0, up_ready8}, 32'd1);
    q8.push_back(exp);
    @(posedge clk); #1;
    up_valid8  = 1'b0;
    up_data8   = ~d;
    up_amount8 = ~up_amount8;
    up_op8     = ~op;
    for (int j = 1; j <= amt + 2; j++) begin
      @(negedge clk);
      chk($sformatf("down_valid_k+%0d", j), {31'd0, down_valid8}, {31'd0, (j == amt + 1)});
      chk($sformatf("up_ready_k+%0d", j), {31'd0, up_ready8}, {31'd0, (j == amt + 2)});
      @(posedge clk); #1;
    end
  endtask

  int acc8, acc16, cyc;
  logic       pend8, pend16;
  logic [7:0] pd8;
  logic [2:0] pa8;
  logic [1:0] po8;
  logic [15:0] pd16;
  logic [3:0]  pa16;
  logic [1:0]  po16;

  initial begin
    rst_n = 1'b0;
    up_valid8 = 1'b0; up_data8 = '0; up_amount8 = '0; up_op8 = '0; down_ready8 = 1'b1;
    up_valid16 = 1'b0; up_data16 = '0; up_amount16 = '0; up_op16 = '0; down_ready16 = 1'b1;

    // Reset state
    #2;
    chk("rst_up_ready8", {31'd0, up_ready8}, 32'd1);
    chk("rst_down_valid8", {31'd0, down_valid8}, 32'd0);
    chk("rst_down_data8", {24'd0, down_data8}, 32'd0);
    chk("rst_up_ready16", {31'd0, up_ready16}, 32'd1);
    chk("rst_down_valid16", {31'd0, down_valid16}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Amount 3, each op on B6, plus arithmetic right of a positive value
    run8(8'hB6, 3, 2'b00, 8'hB0);
    run8(8'hB6, 3, 2'b01, 8'h16);
    run8(8'hB6, 3, 2'b10, 8'hF6);
    run8(8'hB6, 3, 2'b11, 8'hD6);
    run8(8'h36, 3, 2'b10, 8'h06);

    // Amount 0 with the consumer stalled for five cycles
    down_ready8 = 1'b0;
    up_valid8 = 1'b1; up_data8 = 8'hB6; up_amount8 = 3'd0; up_op8 = 2'b11;
    @(negedge clk);
    chk("stall_accept", {31'd0, up_ready8}, 32'd1);
    q8.push_back(8'hB6);
    @(posedge clk); #1;
    up_valid8 = 1'b0; up_data8 = 8'h00;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("stall_down_valid", {31'd0, down_valid8}, 32'd1);
      chk("stall_down_data", {24'd0, down_data8}, 32'hB6);
      chk("stall_up_ready", {31'd0, up_ready8}, 32'd0);
      @(posedge clk); #1;
    end
    down_ready8 = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", {31'd0, down_valid8}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_idle_up_ready", {31'd0, up_ready8}, 32'd1);
    chk("stall_idle_down_valid", {31'd0, down_valid8}, 32'd0);
    @(posedge clk); #1;

    // Maximum amount
    run8(8'h81, 7, 2'b00, 8'h80);
    run8(8'h81, 7, 2'b01, 8'h01);
    run8(8'h81, 7, 2'b10, 8'hFF);
    run8(8'h81, 7, 2'b11, 8'h03);

    // Reset during the second shift cycle of an amount-5 operation
    up_valid8 = 1'b1; up_data8 = 8'hA5; up_amount8 = 3'd5; up_op8 = 2'b00;
    @(negedge clk);
    chk("rstmid_accept", {31'd0, up_ready8}, 32'd1);
    @(posedge clk); #1;
    up_valid8 = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_busy", {31'd0, up_ready8}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_up_ready", {31'd0, up_ready8}, 32'd1);
    chk("rstmid_down_valid", {31'd0, down_valid8}, 32'd0);
    chk("rstmid_down_data", {24'd0, down_data8}, 32'd0);
    up_valid8 = 1'b1; up_data8 = 8'hFF; up_amount8 = 3'd0;
    @(posedge clk); #1;
    chk("rstheld_down_valid", {31'd0, down_valid8}, 32'd0);
    chk("rstheld_down_data", {24'd0, down_data8}, 32'd0);
    up_valid8 = 1'b0;
    rst_n = 1'b1;
    run8(8'h0F, 2, 2'b00, 8'h3C);

    // Random back-to-back streams on both widths with consumer stalls
    acc8 = 0; acc16 = 0; cyc = 0; pend8 = 1'b0; pend16 = 1'b0;
    pd8 = '0; pa8 = '0; po8 = '0; pd16 = '0; pa16 = '0; po16 = '0;
    while ((acc8 < 80 || acc16 < 80 || q8.size() > 0 || q16.size() > 0) && cyc < 20000) begin
      down_ready8  = ($urandom_range(0, 3) != 0);
      down_ready16 = ($urandom_range(0, 3) != 0);
      if (!pend8 && acc8 < 80 && $urandom_range(0, 3) != 0) begin
        pend8 = 1'b1; pd8 = 8'($urandom); pa8 = 3'($urandom_range(0, 7)); po8 = 2'($urandom);
      end
      if (!pend16 && acc16 < 80 && $urandom_range(0, 3) != 0) begin
        pend16 = 1'b1; pd16 = 16'($urandom); pa16 = 4'($urandom_range(0, 15)); po16 = 2'($urandom);
      end
      if (pend8 && $urandom_range(0, 2) != 0) begin
        up_valid8 = 1'b1; up_data8 = pd8; up_amount8 = pa8; up_op8 = po8;
      end else begin
        up_valid8 = 1'b0; up_data8 = 8'($urandom); up_amount8 = 3'($urandom); up_op8 = 2'($urandom);
      end
      if (pend16 && $urandom_range(0, 2) != 0) begin
        up_valid16 = 1'b1; up_data16 = pd16; up_amount16 = pa16; up_op16 = po16;
      end else begin
        up_valid16 = 1'b0; up_data16 = 16'($urandom); up_amount16 = 4'($urandom); up_op16 = 2'($urandom);
      end
      @(negedge clk);
      if (up_valid8 && up_ready8) begin
        q8.push_back(8'(ref_shift({24'd0, pd8}, int'(pa8), po8, 8)));
        pend8 = 1'b0;
        acc8++;
      end
      if (up_valid16 && up_ready16) begin
        q16.push_back(16'(ref_shift({16'd0, pd16}, int'(pa16), po16, 16)));
        pend16 = 1'b0;
        acc16++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    up_valid8 = 1'b0; up_valid16 = 1'b0;
    down_ready8 = 1'b1; down_ready16 = 1'b1;
    chk("rand_accepted8", acc8, 32'd80);
    chk("rand_accepted16", acc16, 32'd80);
    chk("rand_pending8", q8.size(), 32'd0);
    chk("rand_pending16", q16.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
